// File: rtl/onchip_memory_arbiter.sv
// Round-robin arbiter sharing one single-port on-chip RAM between two Avalon-MM requesters.
// Define ONCHIP_ARB_STATS_EN to add saturating grant/conflict counters with a stat_clear input.
module onchip_memory_arbiter #(
  parameter  int ADDR_W = 13,
  parameter  int DATA_W = 32,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] m0_address,
  input  logic [BE_W-1:0]   m0_byteenable,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [DATA_W-1:0] m0_writedata,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic [ADDR_W-1:0] m1_address,
  input  logic [BE_W-1:0]   m1_byteenable,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [DATA_W-1:0] m1_writedata,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata
`ifdef ONCHIP_ARB_STATS_EN
  ,
  input  logic              stat_clear,
  output logic [15:0]       stat_m0_grants,
  output logic [15:0]       stat_m1_grants,
  output logic [15:0]       stat_conflicts
`endif
);

  logic req0, req1, grant0, grant1, rd_issue;
  logic last_grant_q, last_grant_d;
  logic rd_pend_q, rd_pend_d;
  logic rd_tag_q, rd_tag_d;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // Under contention the requester that did not win last time gets the slot.
  assign grant0 = ~reset & req0 & (~req1 | last_grant_q);
  assign grant1 = ~reset & req1 & (~req0 | ~last_grant_q);

  assign m0_waitrequest = reset | (req0 & ~grant0);
  assign m1_waitrequest = reset | (req1 & ~grant1);

  // A simultaneous read+write counts as a write only, so it never launches a read return.
  assign rd_issue = (grant0 & m0_read & ~m0_write) | (grant1 & m1_read & ~m1_write);

  always_comb begin
    // NOTE: every output gets a default before the branches so no path leaves it unassigned (no latch).
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    if (grant0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = m0_write;
    end else if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end
  end

  assign mem_chipselect = grant0 | grant1;
  assign mem_clken      = 1'b1;

  always_comb begin
    rd_pend_d    = rd_issue;
    rd_tag_d     = grant1;
    last_grant_d = (grant0 | grant1) ? grant1 : last_grant_q;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so all of them see pre-edge values.
    if (reset) begin
      last_grant_q <= 1'b1;
      rd_pend_q    <= 1'b0;
      rd_tag_q     <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      rd_pend_q    <= rd_pend_d;
      rd_tag_q     <= rd_tag_d;
    end
  end

  // Gating with reset discards a return whose read was accepted just before reset rose.
  assign m0_readdatavalid = rd_pend_q & ~reset & ~rd_tag_q;
  assign m1_readdatavalid = rd_pend_q & ~reset & rd_tag_q;
  assign m0_readdata      = m0_readdatavalid ? mem_readdata : '0;
  assign m1_readdata      = m1_readdatavalid ? mem_readdata : '0;

`ifdef ONCHIP_ARB_STATS_EN
  logic [15:0] m0_grants_q, m1_grants_q, conflicts_q;

  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      m0_grants_q <= '0;
      m1_grants_q <= '0;
      conflicts_q <= '0;
    end else begin
      if (grant0 && m0_grants_q != 16'hFFFF) m0_grants_q <= m0_grants_q + 16'd1;
      if (grant1 && m1_grants_q != 16'hFFFF) m1_grants_q <= m1_grants_q + 16'd1;
      if (req0 && req1 && conflicts_q != 16'hFFFF) conflicts_q <= conflicts_q + 16'd1;
    end
  end

  assign stat_m0_grants = m0_grants_q;
  assign stat_m1_grants = m1_grants_q;
  assign stat_conflicts = conflicts_q;
`endif

endmodule

// File: tb/tb_onchip_memory_arbiter.sv
// Scoreboard bench for onchip_memory_arbiter: a RAM model, a transaction-level reference and a
// read-return monitor. Stats counters are also checked when ONCHIP_ARB_STATS_EN is defined.
module tb_onchip_memory_arbiter;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  logic clk = 1'b0;
  logic reset;
  logic [ADDR_W-1:0] m0_address, m1_address, mem_address;
  logic [BE_W-1:0]   m0_byteenable, m1_byteenable, mem_byteenable;
  logic              m0_read, m0_write, m1_read, m1_write;
  logic [DATA_W-1:0] m0_writedata, m1_writedata, mem_writedata;
  logic              m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [DATA_W-1:0] m0_readdata, m1_readdata, mem_readdata;
  logic              mem_chipselect, mem_write, mem_clken;
  logic              stat_clear;
`ifdef ONCHIP_ARB_STATS_EN
  logic [15:0] stat_m0_grants, stat_m1_grants, stat_conflicts;
`endif

  onchip_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata)
`ifdef ONCHIP_ARB_STATS_EN
    , .stat_clear(stat_clear), .stat_m0_grants(stat_m0_grants),
    .stat_m1_grants(stat_m1_grants), .stat_conflicts(stat_conflicts)
`endif
  );

  always #5 clk = ~clk;

  // Single-port RAM: registered address, data returned one cycle after the access.
  logic [31:0] ram [0:8191];
  logic [31:0] ram_w;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      mem_readdata <= ram[mem_address];
      if (mem_write) begin
        ram_w = ram[mem_address];
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram_w[8*b +: 8] = mem_writedata[8*b +: 8];
        ram[mem_address] = ram_w;
      end
    end
  end

  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [12:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  logic [31:0] ref_mem [0:8191];
  req_t cur [2];
  exp_t q0[$], q1[$];
  int   last_win;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   mdl_g0, mdl_g1, mdl_conf;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] preload(input int a);
    return (32'(a) * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  function automatic req_t mk(input logic rd, input logic wr, input logic [12:0] a,
                              input logic [3:0] be, input logic [31:0] wd);
    req_t r;
    r.rd = rd; r.wr = wr; r.addr = a; r.be = be; r.wd = wd;
    return r;
  endfunction

  function automatic req_t rand_req();
    int op;
    req_t r;
    op = $urandom_range(0, 99);
    r.rd   = (op < 45) || (op >= 85);
    r.wr   = (op >= 45);
    r.addr = 13'($urandom_range(0, 31));
    if ($urandom_range(0, 9) == 0) r.addr = 13'($urandom);
    r.be   = 4'($urandom);
    r.wd   = $urandom;
    return r;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 16'hFFFF) ? v : v + 1;
  endfunction

  task automatic drive();
    m0_read = cur[0].rd; m0_write = cur[0].wr; m0_address = cur[0].addr;
    m0_byteenable = cur[0].be; m0_writedata = cur[0].wd;
    m1_read = cur[1].rd; m1_write = cur[1].wr; m1_address = cur[1].addr;
    m1_byteenable = cur[1].be; m1_writedata = cur[1].wd;
  endtask

  // One clock: check the arbitration outcome against the model at negedge, then advance.
  task automatic step();
    bit r0, r1;
    int win;
    exp_t e;
    @(negedge clk);
    r0 = cur[0].rd | cur[0].wr;
    r1 = cur[1].rd | cur[1].wr;
    if (reset)         win = -1;
    else if (r0 && r1) win = 1 - last_win;
    else if (r0)       win = 0;
    else if (r1)       win = 1;
    else               win = -1;
    check("m0_waitrequest", m0_waitrequest, reset || (r0 && win != 0));
    check("m1_waitrequest", m1_waitrequest, reset || (r1 && win != 1));
    check("mem_chipselect", mem_chipselect, win >= 0);
    check("mem_clken", mem_clken, 1);
`ifdef ONCHIP_ARB_STATS_EN
    check("stat_m0_grants", stat_m0_grants, mdl_g0);
    check("stat_m1_grants", stat_m1_grants, mdl_g1);
    check("stat_conflicts", stat_conflicts, mdl_conf);
    if (reset || stat_clear) begin
      mdl_g0 = 0; mdl_g1 = 0; mdl_conf = 0;
    end else begin
      if (r0 && r1) mdl_conf = sat_inc(mdl_conf);
      if (win == 0) mdl_g0 = sat_inc(mdl_g0);
      if (win == 1) mdl_g1 = sat_inc(mdl_g1);
    end
`endif
    if (win >= 0) begin
      check("mem_address", mem_address, cur[win].addr);
      check("mem_byteenable", mem_byteenable, cur[win].be);
      check("mem_write", mem_write, cur[win].wr);
      if (cur[win].wr) begin
        check("mem_writedata", mem_writedata, cur[win].wd);
        for (int b = 0; b < 4; b++)
          if (cur[win].be[b]) ref_mem[cur[win].addr][8*b +: 8] = cur[win].wd[8*b +: 8];
      end else begin
        e.data = ref_mem[cur[win].addr];
        e.due  = cyc + 1;
        if (win == 0) q0.push_back(e); else q1.push_back(e);
      end
      last_win = win;
      cur[win] = '0;
    end else begin
      check("mem_write idle", mem_write, 0);
      check("mem_address idle", mem_address, 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      drive();
      step();
    end
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    q0.delete();
    q1.delete();
    last_win = 1;
    run(n);
    reset = 1'b0;
  endtask

  // Read-return monitor: pops the matching requester's queue whenever the DUT returns data.
  always @(negedge clk) begin
    exp_t e;
    if (m0_readdatavalid) begin
      if (q0.size() == 0) check("m0 unexpected readdatavalid", 1, 0);
      else begin
        e = q0.pop_front();
        check("m0_readdata", m0_readdata, e.data);
        check("m0 read latency", cyc, e.due);
      end
    end else begin
      check("m0_readdata idle", m0_readdata, 0);
      if (q0.size() != 0 && q0[0].due <= cyc) begin
        check("m0 missing readdatavalid", 0, 1);
        void'(q0.pop_front());
      end
    end
    if (m1_readdatavalid) begin
      if (q1.size() == 0) check("m1 unexpected readdatavalid", 1, 0);
      else begin
        e = q1.pop_front();
        check("m1_readdata", m1_readdata, e.data);
        check("m1 read latency", cyc, e.due);
      end
    end else begin
      check("m1_readdata idle", m1_readdata, 0);
      if (q1.size() != 0 && q1[0].due <= cyc) begin
        check("m1 missing readdatavalid", 0, 1);
        void'(q1.pop_front());
      end
    end
  end

  initial begin
    for (int a = 0; a < 8192; a++) begin
      ram[a] = preload(a);
      ref_mem[a] = preload(a);
    end
    ram[16] = 32'hCAFEF00D;
    ref_mem[16] = 32'hCAFEF00D;
    cur[0] = '0;
    cur[1] = '0;
    stat_clear = 1'b0;
    mdl_g0 = 0; mdl_g1 = 0; mdl_conf = 0;
    apply_reset(3);

    // Uncontended read of preloaded word.
    cur[0] = mk(1, 0, 13'h0010, 4'hF, 32'h0);
    run(2);

    // Partial write by m0, read back by m1.
    cur[0] = mk(0, 1, 13'h0020, 4'b0011, 32'h12345678);
    run(1);
    cur[1] = mk(1, 0, 13'h0020, 4'hF, 32'h0);
    run(2);

    // Continuous contention from reset: alternating grants starting with m0.
    apply_reset(2);
    for (int k = 0; k < 6; k++) begin
      if (!cur[0].rd) cur[0] = mk(1, 0, 13'(64 + k), 4'hF, 32'h0);
      if (!cur[1].rd) cur[1] = mk(1, 0, 13'(96 + k), 4'hF, 32'h0);
      run(1);
    end
    cur[0] = '0; cur[1] = '0;
    run(1);

    // Read accepted right before reset is discarded; first contention afterwards goes to m0.
    cur[1] = mk(1, 0, 13'h0030, 4'hF, 32'h0);
    run(1);
    apply_reset(2);
    cur[0] = mk(1, 0, 13'h0031, 4'hF, 32'h0);
    cur[1] = mk(1, 0, 13'h0032, 4'hF, 32'h0);
    run(3);

    // Read+write together behaves as a write; later read returns the new data.
    cur[0] = mk(1, 1, 13'h0005, 4'hF, 32'hA5A5A5A5);
    run(1);
    cur[0] = mk(1, 0, 13'h0005, 4'hF, 32'h0);
    run(2);

    // Randomized traffic with occasional resets and stat clears.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 2; i++)
        if (!(cur[i].rd || cur[i].wr) && $urandom_range(0, 9) < 6) cur[i] = rand_req();
      stat_clear = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 199) == 0) apply_reset($urandom_range(1, 2));
      else run(1);
    end
    stat_clear = 1'b0;

`ifdef ONCHIP_ARB_STATS_EN
    // Long contention saturates the conflict counter; clear then zeroes everything.
    for (int k = 0; k < 70000; k++) begin
      if (!cur[0].rd) cur[0] = mk(1, 0, 13'(k % 32), 4'hF, 32'h0);
      if (!cur[1].rd) cur[1] = mk(1, 0, 13'((k + 7) % 32), 4'hF, 32'h0);
      run(1);
    end
    cur[0] = '0; cur[1] = '0;
    run(1);
    check("stat_conflicts saturated", stat_conflicts, 32'hFFFF);
    stat_clear = 1'b1;
    run(1);
    stat_clear = 1'b0;
    run(1);
    check("stat_m0_grants cleared", stat_m0_grants, 0);
    check("stat_m1_grants cleared", stat_m1_grants, 0);
    check("stat_conflicts cleared", stat_conflicts, 0);
`endif

    cur[0] = '0; cur[1] = '0;
    run(3);
    check("scoreboard drained", q0.size() + q1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
